// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard logic.
package pipe_pkg;

  typedef logic [1:0] tnew_t;
  typedef logic [1:0] tuse_t;

  localparam tuse_t       TUSE_NONE       = 2'd3;
  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } md_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_md_busy_counter.sv
// Busy window of the multiply/divide unit: loads on issue from E, counts down to idle.
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A start while busy is dropped: the issuing instruction should have been stalled.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          count_d = is_div ? DivLoad : MultLoad;
          state_d = StBusy;
        end
      end
      StBusy: begin
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (count_q != '0);

  assert property (@(posedge clk) disable iff (reset) !(state_q == StBusy && start))
    else $error("md_busy_counter: mult/div issued while unit busy");

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller: Tuse/Tnew register hazards plus mult/div busy window.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs_addr,
  input  logic [4:0]  d_rt_addr,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_dst,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_dst,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        pc_we,
  output logic        d_we,
  output logic        e_flush,
  output logic        md_busy,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  logic        stall_rs, stall_rt, stall_md;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // $0 is hardwired, so a match on it is never a real dependency.
  function automatic logic reg_hazard(input logic [4:0] src, input tuse_t tuse,
                                      input logic [4:0] edst, input tnew_t etnew,
                                      input logic [4:0] mdst, input tnew_t mtnew);
    logic hit_e, hit_m;
    hit_e = (edst == src) && (etnew > tuse);
    hit_m = (mdst == src) && (mtnew > tuse);
    return (src != REG_ZERO) && (tuse != TUSE_NONE) && (hit_e || hit_m);
  endfunction

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .busy   (md_busy)
  );

  always_comb begin
    stall_rs = reg_hazard(d_rs_addr, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
    stall_rt = reg_hazard(d_rt_addr, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
    stall_md = d_is_md && (e_md_start || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
  end

  assign pc_we   = ~stall;
  assign d_we    = ~stall;
  assign e_flush = stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with hand-computed expectations.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs_addr, d_rt_addr, e_dst, m_dst;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        pc_we, d_we, e_flush, md_busy, stall;
  logic [31:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs_addr   (d_rs_addr),
    .d_rt_addr   (d_rt_addr),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_is_md     (d_is_md),
    .e_dst       (e_dst),
    .e_tnew      (e_tnew),
    .m_dst       (m_dst),
    .m_tnew      (m_tnew),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .pc_we       (pc_we),
    .d_we        (d_we),
    .e_flush     (e_flush),
    .md_busy     (md_busy),
    .stall       (stall),
    .stall_cnt   (stall_cnt)
  );

  task automatic idle_inputs();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 1'b0; e_dst = 5'd0; e_tnew = 2'd0; m_dst = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_vec++; if (pc_we !== 1'b1) begin n_err++; $display("FAIL reset_pc_we got=%b exp=1", pc_we); end
    n_vec++; if (d_we !== 1'b1) begin n_err++; $display("FAIL reset_d_we got=%b exp=1", d_we); end
    n_vec++; if (e_flush !== 1'b0) begin n_err++; $display("FAIL reset_e_flush got=%b exp=0", e_flush); end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL reset_md_busy got=%b exp=0", md_busy); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw $1 in E, addu $x,$1 in D
    e_dst = 5'd1; e_tnew = 2'd2; d_rs_addr = 5'd1; d_tuse_rs = 2'd1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL lu_stall got=%b exp=1", stall); end
    n_vec++; if (pc_we !== 1'b0) begin n_err++; $display("FAIL lu_pc_we got=%b exp=0", pc_we); end
    n_vec++; if (d_we !== 1'b0) begin n_err++; $display("FAIL lu_d_we got=%b exp=0", d_we); end
    n_vec++; if (e_flush !== 1'b1) begin n_err++; $display("FAIL lu_e_flush got=%b exp=1", e_flush); end
    tick();
    n_vec++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt1 got=%h exp=1", stall_cnt); end
    // bubble in E, lw now in M
    e_dst = 5'd0; e_tnew = 2'd0; m_dst = 5'd1; m_tnew = 2'd1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL lu_m_stall got=%b exp=0", stall); end
    tick();
    n_vec++; if (stall_cnt !== 32'd1) begin n_err++; $display("FAIL lu_cnt2 got=%h exp=1", stall_cnt); end
    // rt consumed immediately (e.g. beq) against M result
    d_rs_addr = 5'd0; d_tuse_rs = 2'd3; d_rt_addr = 5'd1; d_tuse_rt = 2'd0;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rt_m_stall got=%b exp=1", stall); end
    idle_inputs();
    #1;
  endtask

  task automatic test_no_hazard();
    e_dst = 5'd0; e_tnew = 2'd2; d_rs_addr = 5'd0; d_tuse_rs = 2'd0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL nh_reg0 got=%b exp=0", stall); end
    e_dst = 5'd5; e_tnew = 2'd1; d_rs_addr = 5'd5; d_tuse_rs = 2'd1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL nh_tnew_eq got=%b exp=0", stall); end
    e_tnew = 2'd2; d_tuse_rs = 2'd3;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL nh_tuse3 got=%b exp=0", stall); end
    d_tuse_rs = 2'd1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL nh_tnew_gt got=%b exp=1", stall); end
    d_rs_addr = 5'd6;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL nh_addr_ne got=%b exp=0", stall); end
    idle_inputs();
    m_dst = 5'd0; m_tnew = 2'd1; d_rt_addr = 5'd0; d_tuse_rt = 2'd0;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL nh_m_reg0 got=%b exp=0", stall); end
    idle_inputs();
    #1;
  endtask

  task automatic test_mult();
    do_reset();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL mult_t_stall got=%b exp=1", stall); end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mult_t_busy got=%b exp=0", md_busy); end
    tick();
    e_md_start = 1'b0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      n_vec++;
      if (md_busy !== 1'b1 || stall !== 1'b1) begin
        n_err++; $display("FAIL mult_busy_t%0d got busy=%b stall=%b exp 1/1", k, md_busy, stall);
      end
      tick();
    end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL mult_t6_busy got=%b exp=0", md_busy); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL mult_t6_stall got=%b exp=0", stall); end
    n_vec++; if (stall_cnt !== 32'd6) begin n_err++; $display("FAIL mult_cnt got=%0d exp=6", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_div();
    do_reset();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL div_t_stall got=%b exp=0", stall); end
    tick();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    #1;
    for (int k = 1; k <= 10; k++) begin
      n_vec++;
      if (md_busy !== 1'b1 || stall !== 1'b0) begin
        n_err++; $display("FAIL div_busy_t%0d got busy=%b stall=%b exp 1/0", k, md_busy, stall);
      end
      tick();
    end
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL div_t11_busy got=%b exp=0", md_busy); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL div_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    tick();
    e_md_start = 1'b0; e_md_is_div = 1'b0;
    // count is 10 now; four more edges bring it to 6
    for (int k = 0; k < 4; k++) tick();
    d_is_md = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rm_pre_stall got=%b exp=1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_vec++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got=%b exp=0", md_busy); end
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL rm_cnt got=%h exp=0", stall_cnt); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rm_mflo_stall got=%b exp=0", stall); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    // register hazard and md hazard together: one stall per cycle
    e_dst = 5'd3; e_tnew = 2'd2; d_rs_addr = 5'd3; d_tuse_rs = 2'd0;
    d_is_md = 1'b1; e_md_start = 1'b1;
    tick();
    e_md_start = 1'b0;
    #1;
    n_vec++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap1 got=%h exp=ffffffff", stall_cnt); end
    tick();
    n_vec++; if (stall_cnt !== 32'h0000_0000) begin n_err++; $display("FAIL wrap2 got=%h exp=00000000", stall_cnt); end
    tick();
    n_vec++; if (stall_cnt !== 32'h0000_0001) begin n_err++; $display("FAIL wrap3 got=%h exp=00000001", stall_cnt); end
    idle_inputs();
    do_reset();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mult();
    test_div();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Hazard and stall controller for the 5-stage MIPS pipeline.
- Drives the write enables of the PC and the F/D register, and the flush of the D/E register.
- Decides stalls from the Tuse/Tnew comparison and from the multiply/divide unit's busy window.
- Owns the mult/div busy counter and a free-running stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues from E.
- DIV_CYCLES, 10, busy cycles after a div/divu issues from E.
- CNT_W, 4, width of the busy counter; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high; clock clk
- d_rs_addr  in  5  rs index of instruction in D
- d_rt_addr  in  5  rt index of instruction in D
- d_tuse_rs  in  2  cycles until D instr needs rs; 3 = not used
- d_tuse_rt  in  2  cycles until D instr needs rt; 3 = not used
- d_is_md  in  1  D instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- e_dst  in  5  destination register of instr in E; 0 = none
- e_tnew  in  2  cycles until E result is available (0..2)
- m_dst  in  5  destination register of instr in M; 0 = none
- m_tnew  in  2  cycles until M result is available (0..1)
- e_md_start  in  1  E instr is mult/multu/div/divu this cycle
- e_md_is_div  in  1  qualifies e_md_start: 1 = div/divu
- pc_we  out  1  PC write enable
- d_we  out  1  F/D register write enable
- e_flush  out  1  clear D/E register to nop (instr 0, pc kept from D)
- md_busy  out  1  busy counter nonzero
- stall  out  1  combined stall
- stall_cnt  out  32  number of cycles with stall=1 since reset

Behaviour:
- Reset values: busy counter 0, stall_cnt 0. md_busy=0. Outputs are combinational from inputs and state; with idle inputs after reset: stall=0, pc_we=1, d_we=1, e_flush=0.
- Register hazard (combinational), rs:
  - stall_rs = (d_rs_addr!=0) & ((e_dst==d_rs_addr & e_tnew>d_tuse_rs) | (m_dst==d_rs_addr & m_tnew>d_tuse_rs)).
  - Comparisons are unsigned 2-bit. Tuse=3 therefore never stalls.
- Register hazard, rt: stall_rt is the same expression using d_rt_addr and d_tuse_rt.
- Register 0 never causes a stall, even when e_dst or m_dst equals 0.
- md hazard: stall_md = d_is_md & (e_md_start | md_busy).
- Stall combination: stall = stall_rs | stall_rt | stall_md; pc_we = d_we = ~stall; e_flush = stall. No extra latency; the effect is visible in the same cycle.
- Busy counter (two states, IDLE = count 0, BUSY = count > 0):
  - IDLE & e_md_start: load MULT_CYCLES, or DIV_CYCLES if e_md_is_div.
  - BUSY: decrement by 1 each cycle; BUSY -> IDLE when the count reaches 0.
  - BUSY & e_md_start: ignored, count keeps decrementing. This cannot occur in legal operation because the issuing instruction was stalled; an assertion flags it.
  - md_busy = (count != 0).
- stall_cnt: increments on every cycle with stall=1. Wraps from 0xFFFFFFFF to 0 silently.
- Reset mid-operation: count and stall_cnt clear on the next edge. A pending mult/div is abandoned.
- Simultaneous register hazard and md hazard: a single stall. stall_cnt increments once.

Decomposition:
- Shared package pipe_pkg:
  - TUSE_NONE = 2'd3.
  - Tnew and Tuse type aliases (2-bit).
  - MULT_CYCLES_DEF and DIV_CYCLES_DEF.
  - REG_ZERO = 5'd0.
- Sub-module md_busy_counter, holding the load/decrement/busy logic. Hazard comparison stays in the top level.

Test Plan:
- lw $1 in E (e_dst=1, e_tnew=2), addu using $1 in D (tuse_rs=1) -> stall=1, pc_we=0, e_flush=1. Next cycle, lw in M (m_tnew=1): stall=0.
- e_dst=0, e_tnew=2, d_rs_addr=0, tuse_rs=0 -> stall=0. Also e_dst=5, e_tnew=1, tuse_rs=1 -> stall=0 (Tnew not greater than Tuse).
- e_md_start=1, e_md_is_div=0 at edge t, with mfhi held in D -> stall=1 at cycle t, md_busy=1 for cycles t+1..t+5, stall=0 at t+6.
- div issue at edge t with d_is_md=0 -> md_busy high exactly 10 cycles, stall stays 0 throughout.
- div in progress (count=6), reset=1 for one cycle -> md_busy=0 and stall_cnt=0 on the next cycle. A mflo in D no longer stalls.
- Preload stall_cnt to 0xFFFFFFFE via force, hold stall for 3 cycles -> values 0xFFFFFFFF, 0x00000000, 0x00000001.
